// File: rtl/nes_joypad_pkg.sv
// Shared constants for the NES joypad responder: button indices, frame width, FSM encoding.
package nes_joypad_pkg;

  localparam int JP_BITS   = 8;

  localparam int BTN_A     = 0;
  localparam int BTN_B     = 1;
  localparam int BTN_SEL   = 2;
  localparam int BTN_START = 3;
  localparam int BTN_UP    = 4;
  localparam int BTN_DOWN  = 5;
  localparam int BTN_LEFT  = 6;
  localparam int BTN_RIGHT = 7;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/jp_edge_filter.sv
// Synchroniser chain plus run-length filter for one console strobe pin; emits the
// accepted level and single-cycle rise/fall pulses derived from it.
module jp_edge_filter #(
  parameter int   SYNC_STAGES = 2,
  parameter int   FILTER_LEN  = 3,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam logic [3:0] RUN_LOAD = 4'(FILTER_LEN - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [3:0]             run_cnt;
  logic                   level_d;
  logic                   synced;

  assign synced = sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync    <= {SYNC_STAGES{RESET_VAL}};
      run_cnt <= RUN_LOAD;
      level   <= RESET_VAL;
      level_d <= RESET_VAL;
    end else begin
      sync    <= {sync[SYNC_STAGES-2:0], din};
      level_d <= level;
      // down-counter reloads on agreement; terminal count accepts the new level
      if (synced == level) begin
        run_cnt <= RUN_LOAD;
      end else if (run_cnt == 4'd0) begin
        level   <= synced;
        run_cnt <= RUN_LOAD;
      end else begin
        run_cnt <= run_cnt - 4'd1;
      end
    end
  end

  assign rise = level & ~level_d;
  assign fall = ~level & level_d;

endmodule

// File: rtl/nes_joypad_responder.sv
// Pad-side model of the NES 4021 shift register: conditions console strobes and
// board buttons, then serialises the latched button vector onto jp_data.
module nes_joypad_responder
  import nes_joypad_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int FILTER_LEN   = 3,
  parameter int DEBOUNCE_CYC = 250000
) (
  input  logic               CLK_50MHZ,
  input  logic               reset,
  input  logic [JP_BITS-1:0] btn_n,
  input  logic               jp_latch,
  input  logic               jp_clk,
  output logic               jp_data,
  output logic [3:0]         bit_cnt,
  output logic               read_done,
  output logic [JP_BITS-1:0] snapshot_n
);

  // state | meaning
  // IDLE  | after reset, drive shift_reg[0] and wait for a latch
  // LOAD  | latch high, shift_reg follows debounced buttons
  // SHIFT | latch released, each clk rise shifts one bit out
  // DONE  | all 8 bits sent, data stays 1 until next latch

  logic latch_lvl, latch_rise, latch_fall;
  logic clk_lvl, clk_rise, clk_fall;
  logic unused_clk;

  jp_edge_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN), .RESET_VAL(1'b0)) u_latch_flt (
    .clk(CLK_50MHZ), .rst_n(reset), .din(jp_latch),
    .level(latch_lvl), .rise(latch_rise), .fall(latch_fall)
  );

  jp_edge_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN), .RESET_VAL(1'b1)) u_clk_flt (
    .clk(CLK_50MHZ), .rst_n(reset), .din(jp_clk),
    .level(clk_lvl), .rise(clk_rise), .fall(clk_fall)
  );

  assign unused_clk = clk_lvl ^ clk_fall;

  logic [SYNC_STAGES-1:0] btn_sync [JP_BITS];
  logic [JP_BITS-1:0]     btn_db;

  for (genvar g = 0; g < JP_BITS; g++) begin : g_btn
    always_ff @(posedge CLK_50MHZ or negedge reset) begin
      if (!reset) btn_sync[g] <= '1;
      else        btn_sync[g] <= {btn_sync[g][SYNC_STAGES-2:0], btn_n[g]};
    end

    if (DEBOUNCE_CYC == 0) begin : g_bypass
      assign btn_db[g] = btn_sync[g][SYNC_STAGES-1];
    end else begin : g_deb
      localparam int DB_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
      localparam logic [DB_W-1:0] DB_LOAD = DB_W'(DEBOUNCE_CYC - 1);
      logic [DB_W-1:0] db_cnt;
      logic            db_q;

      always_ff @(posedge CLK_50MHZ or negedge reset) begin
        if (!reset) begin
          db_cnt <= DB_LOAD;
          db_q   <= 1'b1;
        end else if (btn_sync[g][SYNC_STAGES-1] == db_q) begin
          db_cnt <= DB_LOAD;
        end else if (db_cnt == '0) begin
          db_q   <= btn_sync[g][SYNC_STAGES-1];
          db_cnt <= DB_LOAD;
        end else begin
          db_cnt <= db_cnt - 1'b1;
        end
      end

      assign btn_db[g] = db_q;
    end
  end

  logic [1:0]         state, state_nxt;
  logic [JP_BITS-1:0] shift_reg, sr_nxt, snap_nxt;
  logic [3:0]         cnt_nxt;
  logic               done_nxt;

  always_comb begin
    state_nxt = state;
    sr_nxt    = shift_reg;
    cnt_nxt   = bit_cnt;
    snap_nxt  = snapshot_n;
    done_nxt  = 1'b0;
    // a new latch always restarts the frame, abandoning any partial read silently
    if (latch_rise) begin
      state_nxt = ST_LOAD;
      sr_nxt    = btn_db;
      cnt_nxt   = 4'd0;
    end else begin
      case (state)
        ST_LOAD: begin
          sr_nxt  = btn_db;
          cnt_nxt = 4'd0;
          if (latch_fall) begin
            snap_nxt  = shift_reg;
            state_nxt = ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (clk_rise && !latch_lvl) begin
            sr_nxt  = {1'b1, shift_reg[JP_BITS-1:1]};
            cnt_nxt = bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              done_nxt  = 1'b1;
              state_nxt = ST_DONE;
            end
          end
        end
        ST_DONE: sr_nxt = '1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK_50MHZ or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      shift_reg  <= '1;
      snapshot_n <= '1;
      bit_cnt    <= 4'd0;
      read_done  <= 1'b0;
      jp_data    <= 1'b1;
    end else begin
      state      <= state_nxt;
      shift_reg  <= sr_nxt;
      snapshot_n <= snap_nxt;
      bit_cnt    <= cnt_nxt;
      read_done  <= done_nxt;
      jp_data    <= sr_nxt[0];
    end
  end

endmodule

// File: tb/tb_nes_joypad_responder.sv
// Directed and randomized reads of the joypad responder against a frame-level model.
module tb_nes_joypad_responder;

  logic       clk_50 = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] btn_n = 8'hFF;
  logic       jp_latch = 1'b0;
  logic       jp_clk = 1'b1;
  logic       jp_data;
  logic [3:0] bit_cnt;
  logic       read_done;
  logic [7:0] snapshot_n;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;

  nes_joypad_responder #(.SYNC_STAGES(2), .FILTER_LEN(3), .DEBOUNCE_CYC(100)) dut (
    .CLK_50MHZ(clk_50), .reset(reset), .btn_n(btn_n), .jp_latch(jp_latch), .jp_clk(jp_clk),
    .jp_data(jp_data), .bit_cnt(bit_cnt), .read_done(read_done), .snapshot_n(snapshot_n)
  );

  always #10 clk_50 = ~clk_50;

  always @(posedge clk_50) if (read_done) done_cnt <= done_cnt + 1;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_50);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // frame model: bit k of a read is the pad's btn_n[k] for k<8, then constant 1
  function automatic logic exp_bit(input logic [7:0] b, input int k);
    return (k < 8) ? b[k] : 1'b1;
  endfunction

  function automatic logic [3:0] exp_cnt(input int k);
    return (k > 8) ? 4'd8 : 4'(k);
  endfunction

  task automatic latch_pulse(input int len);
    jp_latch = 1'b1;
    cyc(len);
    jp_latch = 1'b0;
    cyc(25);
  endtask

  task automatic clk_pulse();
    jp_clk = 1'b0;
    cyc(25);
    jp_clk = 1'b1;
    cyc(25);
  endtask

  task automatic read_check(input string tag, input logic [7:0] b, input int first, input int n);
    for (int k = first; k < first + n; k++) begin
      chk($sformatf("%s_data%0d", tag, k), 32'(jp_data), 32'(exp_bit(b, k)));
      chk($sformatf("%s_cnt%0d", tag, k), 32'(bit_cnt), 32'(exp_cnt(k)));
      clk_pulse();
    end
    chk($sformatf("%s_data_end", tag), 32'(jp_data), 32'(exp_bit(b, first + n)));
    chk($sformatf("%s_cnt_end", tag), 32'(bit_cnt), 32'(exp_cnt(first + n)));
  endtask

  initial begin
    int d0;
    logic [7:0] b;
    int n;

    // reset held low with all buttons pressed
    btn_n = 8'h00;
    #5 reset = 1'b0;
    #40;
    chk("rst_data_during", 32'(jp_data), 32'd1);
    chk("rst_snap_during", 32'(snapshot_n), 32'hFF);
    chk("rst_cnt_during", 32'(bit_cnt), 32'd0);
    #40;
    @(negedge clk_50);
    reset = 1'b1;
    cyc(5);
    chk("rst_data_after", 32'(jp_data), 32'd1);
    chk("rst_snap_after", 32'(snapshot_n), 32'hFF);
    chk("rst_cnt_after", 32'(bit_cnt), 32'd0);
    chk("rst_done_after", 32'(read_done), 32'd0);

    // full read with A held
    b = 8'b1111_1110;
    btn_n = b;
    cyc(150);
    d0 = done_cnt;
    latch_pulse(600);
    chk("full_snap", 32'(snapshot_n), 32'(b));
    read_check("full", b, 0, 8);
    chk("full_done", 32'(done_cnt - d0), 32'd1);

    // overread
    d0 = done_cnt;
    read_check("over", b, 8, 8);
    chk("over_done", 32'(done_cnt - d0), 32'd0);

    // abort a partial read, then read Right
    d0 = done_cnt;
    latch_pulse(600);
    read_check("abort_part", b, 0, 3);
    b = 8'b0111_1111;
    btn_n = b;
    cyc(150);
    chk("abort_hidden", 32'(jp_data), 32'(exp_bit(8'b1111_1110, 3)));
    latch_pulse(600);
    chk("abort_snap", 32'(snapshot_n), 32'(b));
    read_check("abort_read", b, 0, 8);
    chk("abort_done", 32'(done_cnt - d0), 32'd1);

    // glitches of 1 and FILTER_LEN-1 cycles on jp_clk
    b = 8'b1010_0101;
    btn_n = b;
    cyc(150);
    latch_pulse(600);
    read_check("glitch_pre", b, 0, 2);
    jp_clk = 1'b0; cyc(1); jp_clk = 1'b1; cyc(20);
    chk("glitch1_cnt", 32'(bit_cnt), 32'd2);
    chk("glitch1_data", 32'(jp_data), 32'(exp_bit(b, 2)));
    jp_clk = 1'b0; cyc(2); jp_clk = 1'b1; cyc(20);
    chk("glitch2_cnt", 32'(bit_cnt), 32'd2);
    chk("glitch2_data", 32'(jp_data), 32'(exp_bit(b, 2)));
    read_check("glitch_post", b, 2, 6);

    // debounce: Start chatters faster than the debounce window
    btn_n = 8'hFF;
    cyc(150);
    for (int i = 0; i < 6; i++) begin
      btn_n[3] = ~btn_n[3];
      cyc(10);
      jp_latch = 1'b1; cyc(10); jp_latch = 1'b0; cyc(20);
      chk($sformatf("deb_toggle%0d", i), 32'(snapshot_n), 32'hFF);
    end
    btn_n[3] = 1'b0;
    cyc(150);
    latch_pulse(600);
    chk("deb_hold_snap", 32'(snapshot_n), 32'hF7);
    read_check("deb_read", 8'hF7, 0, 8);

    // async reset in the middle of a read
    b = 8'h3C;
    btn_n = b;
    cyc(150);
    d0 = done_cnt;
    latch_pulse(600);
    read_check("arst_pre", b, 0, 3);
    #3 reset = 1'b0;
    #1;
    chk("arst_data", 32'(jp_data), 32'd1);
    chk("arst_cnt", 32'(bit_cnt), 32'd0);
    chk("arst_snap", 32'(snapshot_n), 32'hFF);
    cyc(2);
    reset = 1'b1;
    cyc(2);
    clk_pulse();
    chk("arst_idle_cnt", 32'(bit_cnt), 32'd0);
    chk("arst_idle_data", 32'(jp_data), 32'd1);
    chk("arst_done", 32'(done_cnt - d0), 32'd0);

    // randomized reads of random length
    for (int r = 0; r < 6; r++) begin
      b = 8'($urandom);
      n = $urandom_range(0, 11);
      btn_n = b;
      cyc(150);
      d0 = done_cnt;
      latch_pulse(600);
      chk($sformatf("rnd%0d_snap", r), 32'(snapshot_n), 32'(b));
      read_check($sformatf("rnd%0d", r), b, 0, n);
      chk($sformatf("rnd%0d_done", r), 32'(done_cnt - d0), (n >= 8) ? 32'd1 : 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
